multicycle_controller: RTL and testbench

Sequencing controller that turns the 16-bit processor datapath into a multi-cycle machine. One shared memory port carries both instruction fetch and data access, and one ALU handles PC increment, address and arithmetic. Each instruction is stepped through FETCH/DECODE/EXEC/MEM/WB states, with a request/ready handshake to memory. The block sits beside the datapath in place of the combinational opcode decoder and drives every datapath strobe and mux select.

---
 rtl/multicycle_controller.sv | 175 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing controller: steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
// Define ILLEGAL_TRAP_EN to trap unlisted opcodes into HALT; otherwise they run as ADD.
module multicycle_controller #(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [3:0]          opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                reg_write,
  output logic                reg_dest,
  output logic                mem_to_reg,
  output logic                jal,
  output logic [2:0]          state,
  output logic                retire,
  output logic [RETIRE_W-1:0] retired_count,
  output logic                illegal
);
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
  } state_t;
  typedef enum logic [2:0] {K_ADD, K_NDU, K_LW, K_SW, K_BEQ, K_JAL, K_ILL} kind_t;

  state_t              state_q, state_d;
  kind_t               kind_q, kind_d;
  logic                pend_q, pend_d;
  logic                ill_q, ill_d;
  logic [RETIRE_W-1:0] cnt_q, cnt_d;

  logic       req_c, we_c, iord_c, irw_c, pcw_c, pcwc_c, pcsrc_c, asa_c;
  logic [1:0] asb_c, aop_c;
  logic       rw_c, rd_c, m2r_c, jal_c, ret_c;

  // The branch decision is made by the datapath gating pc_write_cond with zero.
  logic unused_zero;
  assign unused_zero = zero;

  function automatic kind_t decode(input logic [3:0] op);
    case (op)
      4'b0000: decode = K_ADD;
      4'b0010: decode = K_NDU;
      4'b0100: decode = K_LW;
      4'b0101: decode = K_SW;
      4'b1100: decode = K_BEQ;
      4'b1000: decode = K_JAL;
`ifdef ILLEGAL_TRAP_EN
      default: decode = K_ILL;
`else
      default: decode = K_ADD;
`endif
    endcase
  endfunction

  always_comb begin
    state_d = state_q; kind_d = kind_q; pend_d = pend_q; ill_d = ill_q; cnt_d = cnt_q;
    req_c = 1'b0; we_c = 1'b0; iord_c = 1'b0; irw_c = 1'b0; pcw_c = 1'b0; pcwc_c = 1'b0;
    pcsrc_c = 1'b0; asa_c = 1'b0; asb_c = 2'b00; aop_c = 2'b00;
    rw_c = 1'b0; rd_c = 1'b0; m2r_c = 1'b0; jal_c = 1'b0; ret_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        // Once a fetch has been requested it is held even if run drops.
        req_c = run | pend_q;
        if (req_c) begin
          if (mem_ready) begin
            irw_c = 1'b1; pcw_c = 1'b1; asb_c = 2'b01;
            pend_d = 1'b0; state_d = S_DECODE;
          end else begin
            pend_d = 1'b1;
          end
        end
      end
      S_DECODE: begin
        kind_d  = decode(opcode);
        state_d = S_EXEC;
`ifdef ILLEGAL_TRAP_EN
        if (kind_d == K_ILL) begin
          state_d = S_HALT;
          ill_d   = 1'b1;
        end
`endif
      end
      S_EXEC: begin
        case (kind_q)
          K_LW, K_SW: begin
            asa_c = 1'b1; asb_c = 2'b10; state_d = S_MEM;
          end
          K_BEQ: begin
            asa_c = 1'b1; aop_c = 2'b01; pcwc_c = 1'b1; pcsrc_c = 1'b1; ret_c = 1'b1;
            state_d = S_FETCH;
          end
          K_JAL: begin
            rw_c = 1'b1; jal_c = 1'b1; pcw_c = 1'b1; pcsrc_c = 1'b1; ret_c = 1'b1;
            state_d = S_FETCH;
          end
          K_NDU: begin
            asa_c = 1'b1; aop_c = 2'b10; state_d = S_WB;
          end
          default: begin
            asa_c = 1'b1; state_d = S_WB;
          end
        endcase
      end
      S_MEM: begin
        req_c = 1'b1; iord_c = 1'b1; we_c = (kind_q == K_SW);
        if (mem_ready) begin
          if (kind_q == K_SW) begin
            ret_c = 1'b1; state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rw_c = 1'b1; ret_c = 1'b1; state_d = S_FETCH;
        if (kind_q == K_LW) begin
          m2r_c = 1'b1;
        end else begin
          asa_c = 1'b1; rd_c = 1'b1;
          aop_c = (kind_q == K_NDU) ? 2'b10 : 2'b00;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    if (ret_c) cnt_d = cnt_q + RETIRE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      kind_q  <= K_ADD;
      pend_q  <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      pend_q  <= pend_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  // Everything is forced low during reset so an abandoned access cannot write or retire.
  assign mem_req       = ~rst & req_c;
  assign mem_we        = ~rst & we_c;
  assign iord          = ~rst & iord_c;
  assign ir_write      = ~rst & irw_c;
  assign pc_write      = ~rst & pcw_c;
  assign pc_write_cond = ~rst & pcwc_c;
  assign pc_src        = ~rst & pcsrc_c;
  assign alu_src_a     = ~rst & asa_c;
  assign alu_src_b     = rst ? 2'b00 : asb_c;
  assign alu_op        = rst ? 2'b00 : aop_c;
  assign reg_write     = ~rst & rw_c;
  assign reg_dest      = ~rst & rd_c;
  assign mem_to_reg    = ~rst & m2r_c;
  assign jal           = ~rst & jal_c;
  assign retire        = ~rst & ret_c;
  assign state         = rst ? 3'd0 : state_q;
  assign retired_count = rst ? '0 : cnt_q;
  assign illegal       = ~rst & ill_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle state/strobe vectors checked against hand-computed values.
module tb_multicycle_controller;
  localparam int RW = 3;  // narrow counter so the wrap is reachable in a few instructions

  localparam logic [16:0] REQ = 17'h1 << 16, WE = 17'h1 << 15, IORD = 17'h1 << 14,
    IRW = 17'h1 << 13, PCW = 17'h1 << 12, PCWC = 17'h1 << 11, PCSRC = 17'h1 << 10,
    ASA = 17'h1 << 9, ASB_2 = 17'h1 << 7, ASB_I = 17'h2 << 7, AOP_SUB = 17'h1 << 5,
    AOP_NAND = 17'h2 << 5, RWR = 17'h1 << 4, RD = 17'h1 << 3, M2R = 17'h1 << 2,
    JAL = 17'h1 << 1, RET = 17'h1;
  localparam logic [16:0] FETCH_OK = REQ | IRW | PCW | ASB_2;

  logic clk = 1'b0, rst = 1'b1, run = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src, alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic reg_write, reg_dest, mem_to_reg, jal, retire, illegal;
  logic [2:0] state;
  logic [RW-1:0] retired_count;
  logic [16:0] strobes;
  int n_cmp = 0, n_err = 0;

  multicycle_controller #(.RETIRE_W(RW)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .reg_dest(reg_dest),
    .mem_to_reg(mem_to_reg), .jal(jal), .state(state), .retire(retire),
    .retired_count(retired_count), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign strobes = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
                    alu_src_a, alu_src_b, alu_op, reg_write, reg_dest, mem_to_reg, jal, retire};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then check state and strobes mid-phase.
  task automatic cyc(input string tag, input logic rs, input logic r, input logic [3:0] op,
                     input logic z, input logic rdy, input logic [2:0] est, input logic [16:0] estr);
    @(negedge clk);
    rst = rs; run = r; opcode = op; zero = z; mem_ready = rdy;
    #1;
    chk({tag, ".state"}, 32'(state), 32'(est));
    chk({tag, ".strobes"}, 32'(strobes), 32'(estr));
  endtask

  task automatic cnt(input string tag, input int exp);
    @(posedge clk); #1;
    chk({tag, ".count"}, 32'(retired_count), 32'(exp));
  endtask

  initial begin
    cyc("rst", 1, 1, 4'h0, 0, 1, 3'd0, 17'h0);
    chk("rst.count", 32'(retired_count), 32'd0);
    chk("rst.illegal", 32'(illegal), 32'd0);
    cnt("rst", 0);

    // ADD: 0,1,2,4
    cyc("add.f", 0, 1, 4'h0, 0, 1, 3'd0, FETCH_OK);
    cyc("add.d", 0, 1, 4'h0, 0, 1, 3'd1, 17'h0);
    cyc("add.e", 0, 1, 4'h0, 0, 1, 3'd2, ASA);
    cyc("add.w", 0, 1, 4'h0, 0, 1, 3'd4, RWR | RET | ASA | RD);
    cnt("add", 1);

    // LW with two MEM wait cycles: 7 cycles total
    cyc("lw.f", 0, 1, 4'h4, 0, 1, 3'd0, FETCH_OK);
    cyc("lw.d", 0, 1, 4'h4, 0, 1, 3'd1, 17'h0);
    cyc("lw.e", 0, 1, 4'h4, 0, 1, 3'd2, ASA | ASB_I);
    cyc("lw.m0", 0, 1, 4'h4, 0, 0, 3'd3, REQ | IORD);
    cyc("lw.m1", 0, 1, 4'h4, 0, 0, 3'd3, REQ | IORD);
    cyc("lw.m2", 0, 1, 4'h4, 0, 1, 3'd3, REQ | IORD);
    cyc("lw.w", 0, 1, 4'h4, 0, 1, 3'd4, RWR | RET | M2R);
    cnt("lw", 2);

    // BEQ taken and not taken: same strobes, 3 cycles each
    cyc("beq1.f", 0, 1, 4'hC, 1, 1, 3'd0, FETCH_OK);
    cyc("beq1.d", 0, 1, 4'hC, 1, 1, 3'd1, 17'h0);
    cyc("beq1.e", 0, 1, 4'hC, 1, 1, 3'd2, ASA | AOP_SUB | PCWC | PCSRC | RET);
    cnt("beq1", 3);
    cyc("beq0.f", 0, 1, 4'hC, 0, 1, 3'd0, FETCH_OK);
    cyc("beq0.d", 0, 1, 4'hC, 0, 1, 3'd1, 17'h0);
    cyc("beq0.e", 0, 1, 4'hC, 0, 1, 3'd2, ASA | AOP_SUB | PCWC | PCSRC | RET);
    cnt("beq0", 4);

    cyc("jal.f", 0, 1, 4'h8, 0, 1, 3'd0, FETCH_OK);
    cyc("jal.d", 0, 1, 4'h8, 0, 1, 3'd1, 17'h0);
    cyc("jal.e", 0, 1, 4'h8, 0, 1, 3'd2, RWR | JAL | PCW | PCSRC | RET);
    cnt("jal", 5);

    cyc("ndu.f", 0, 1, 4'h2, 0, 1, 3'd0, FETCH_OK);
    cyc("ndu.d", 0, 1, 4'h2, 0, 1, 3'd1, 17'h0);
    cyc("ndu.e", 0, 1, 4'h2, 0, 1, 3'd2, ASA | AOP_NAND);
    cyc("ndu.w", 0, 1, 4'h2, 0, 1, 3'd4, RWR | RET | ASA | RD | AOP_NAND);
    cnt("ndu", 6);

    // SW with fetch wait; run dropped mid-handshake and mid-instruction must not stall
    cyc("sw.f0", 0, 1, 4'h5, 0, 0, 3'd0, REQ);
    cyc("sw.f1", 0, 0, 4'h5, 0, 0, 3'd0, REQ);
    cyc("sw.f2", 0, 0, 4'h5, 0, 1, 3'd0, FETCH_OK);
    cyc("sw.d", 0, 0, 4'h5, 0, 1, 3'd1, 17'h0);
    cyc("sw.e", 0, 0, 4'h5, 0, 1, 3'd2, ASA | ASB_I);
    cyc("sw.m0", 0, 0, 4'h5, 0, 0, 3'd3, REQ | IORD | WE);
    cyc("sw.m1", 0, 0, 4'h5, 0, 1, 3'd3, REQ | IORD | WE | RET);
    cnt("sw", 7);
    for (int i = 0; i < 3; i++) cyc("idle", 0, 0, 4'h0, 0, 1, 3'd0, 17'h0);

    // Counter wraps 7 -> 0
    cyc("wrap.f", 0, 1, 4'hC, 0, 1, 3'd0, FETCH_OK);
    cyc("wrap.d", 0, 1, 4'hC, 0, 1, 3'd1, 17'h0);
    cyc("wrap.e", 0, 1, 4'hC, 0, 1, 3'd2, ASA | AOP_SUB | PCWC | PCSRC | RET);
    cnt("wrap", 0);
    cyc("pre.f", 0, 1, 4'h0, 0, 1, 3'd0, FETCH_OK);
    cyc("pre.d", 0, 1, 4'h0, 0, 1, 3'd1, 17'h0);
    cyc("pre.e", 0, 1, 4'h0, 0, 1, 3'd2, ASA);
    cyc("pre.w", 0, 1, 4'h0, 0, 1, 3'd4, RWR | RET | ASA | RD);
    cnt("pre", 1);

    // Reset during an SW wait in MEM abandons it
    cyc("swr.f", 0, 1, 4'h5, 0, 1, 3'd0, FETCH_OK);
    cyc("swr.d", 0, 1, 4'h5, 0, 1, 3'd1, 17'h0);
    cyc("swr.e", 0, 1, 4'h5, 0, 1, 3'd2, ASA | ASB_I);
    cyc("swr.m", 0, 1, 4'h5, 0, 0, 3'd3, REQ | IORD | WE);
    cyc("swr.rst", 1, 1, 4'h5, 0, 1, 3'd0, 17'h0);
    cnt("swr", 0);

    for (int i = 0; i < 5; i++) cyc("run0", 0, 0, 4'h0, 0, 1, 3'd0, 17'h0);
    cyc("run1", 0, 1, 4'h0, 0, 0, 3'd0, REQ);
    cyc("run1.f", 0, 1, 4'hF, 0, 1, 3'd0, FETCH_OK);
    cyc("ill.d", 0, 1, 4'hF, 0, 1, 3'd1, 17'h0);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      cyc("halt", 0, 1, 4'hF, 0, 1, 3'd5, 17'h0);
      chk("halt.illegal", 32'(illegal), 32'd1);
    end
    cnt("halt", 0);
    cyc("halt.rst", 1, 1, 4'h0, 0, 1, 3'd0, 17'h0);
    cyc("post", 0, 0, 4'h0, 0, 1, 3'd0, 17'h0);
    chk("post.illegal", 32'(illegal), 32'd0);
`else
    cyc("ill.e", 0, 1, 4'hF, 0, 1, 3'd2, ASA);
    cyc("ill.w", 0, 1, 4'hF, 0, 1, 3'd4, RWR | RET | ASA | RD);
    chk("ill.illegal", 32'(illegal), 32'd0);
    cnt("ill", 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
